// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- parametrised multi-port integer register file
//
// Registered (one-cycle) reads with write-first forwarding, optional hardwired
// zero register and a per-register pending-write scoreboard used by decode to
// detect RAW hazards against instructions still in flight to writeback.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   rd_en     [NUM_RD]          per-port read enable
//   rd_addr   [NUM_RD*ADDR_W]   read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data   [NUM_RD*DATA_W]   registered read data, packed like rd_addr
//   rd_busy   [NUM_RD]          registered pending flag of the addressed register
//   wr_en     [NUM_WR]          per-port write enable
//   wr_addr   [NUM_WR*ADDR_W]   write addresses
//   wr_data   [NUM_WR*DATA_W]   write data
//   sb_set    mark register sb_addr as pending
//   sb_addr   [ADDR_W]          scoreboard set address
//   sb_flush  clear every pending flag
// -----------------------------------------------------------------------------
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     sb_set,
   input  logic [ADDR_W-1:0]        sb_addr,
   input  logic                     sb_flush
);

   logic [DATA_W-1:0] mem_reg  [DEPTH];
   logic [DATA_W-1:0] mem_next [DEPTH];
   logic [DEPTH-1:0]  busy_reg;
   logic [DEPTH-1:0]  busy_next;
   logic [DEPTH-1:0]  wr_hit;

   // Next-state register contents. Ports are scanned in ascending order so the
   // highest-indexed port targeting a register is the one that lands.
   always_comb begin
      for (int r = 0; r < DEPTH; r++) begin
         mem_next[r] = mem_reg[r];
         wr_hit[r]   = 1'b0;
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
               mem_next[r] = wr_data[j*DATA_W +: DATA_W];
               wr_hit[r]   = 1'b1;
            end
         end
      end
      if (ZERO_REG != 0) begin
         mem_next[0] = '0;
      end
   end

   // Scoreboard: flush beats everything; a new issue (set) beats a retiring
   // write-clear on the same register because the new producer is younger.
   always_comb begin
      busy_next = busy_reg;
      if (sb_flush) begin
         busy_next = '0;
      end else begin
         busy_next = busy_reg & ~wr_hit;
         if (sb_set) begin
            busy_next[sb_addr] = 1'b1;
         end
      end
      if (ZERO_REG != 0) begin
         busy_next[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DEPTH; r++) begin
            mem_reg[r] <= '0;
         end
         busy_reg <= '0;
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            mem_reg[r] <= mem_next[r];
         end
         busy_reg <= busy_next;
      end
   end

   // Read ports sample the post-edge view (mem_next / busy_next), which gives
   // write-first forwarding and keeps data and busy consistent with each other.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] addr;
         logic [DATA_W-1:0] data_reg;
         logic              busy_out_reg;

         assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data_reg     <= '0;
               busy_out_reg <= 1'b0;
            end else if (rd_en[gi]) begin
               data_reg     <= mem_next[addr];
               busy_out_reg <= busy_next[addr];
            end
         end

         assign rd_data[gi*DATA_W +: DATA_W] = data_reg;
         assign rd_busy[gi]                  = busy_out_reg;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp -- self-checking bench for regfile_mp
//
// Two instances share the same stimulus: dut_z (ZERO_REG=1) and dut_n
// (ZERO_REG=0), both with 2 read and 2 write ports. Every clock both are
// compared against an array-based reference model; directed table rows and
// hand-written sequences additionally compare against literal expectations.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        sb_set;
   logic [4:0]  sb_addr;
   logic        sb_flush;

   logic [63:0] rd_data_z, rd_data_n;
   logic [1:0]  rd_busy_z, rd_busy_n;

   int vec_cnt = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut_z (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_z), .rd_busy(rd_busy_z), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush)
   );

   regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0)) dut_n (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_n), .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush)
   );

   // ---------------- reference model (index 0 = dut_z, 1 = dut_n) ----------
   logic [31:0] m_mem  [2][32];
   logic        m_busy [2][32];
   logic [31:0] m_rd   [2][2];
   logic        m_rb   [2][2];

   task automatic model_clear(input int d);
      for (int r = 0; r < 32; r++) begin
         m_mem[d][r]  = '0;
         m_busy[d][r] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         m_rd[d][i] = '0;
         m_rb[d][i] = 1'b0;
      end
   endtask

   task automatic model_step();
      logic [31:0] nm [32];
      logic        nb [32];
      int          a;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            model_clear(d);
         end else begin
            for (int r = 0; r < 32; r++) begin
               nm[r] = m_mem[d][r];
               nb[r] = m_busy[d][r];
            end
            // later port overwrites earlier one
            for (int j = 0; j < 2; j++) begin
               a = int'(wr_addr[j*5 +: 5]);
               if (wr_en[j] && !(d == 0 && a == 0)) nm[a] = wr_data[j*32 +: 32];
            end
            if (sb_flush) begin
               for (int r = 0; r < 32; r++) nb[r] = 1'b0;
            end else begin
               for (int j = 0; j < 2; j++)
                  if (wr_en[j]) nb[int'(wr_addr[j*5 +: 5])] = 1'b0;
               if (sb_set) nb[int'(sb_addr)] = 1'b1;
            end
            if (d == 0) nb[0] = 1'b0;
            for (int i = 0; i < 2; i++) begin
               if (rd_en[i]) begin
                  a = int'(rd_addr[i*5 +: 5]);
                  m_rd[d][i] = nm[a];
                  m_rb[d][i] = nb[a];
               end
            end
            for (int r = 0; r < 32; r++) begin
               m_mem[d][r]  = nm[r];
               m_busy[d][r] = nb[r];
            end
         end
      end
   endtask

   // ---------------- checking --------------------------------------------
   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   task automatic check_model(input string tag);
      chk({tag, " z.data"}, rd_data_z, {m_rd[0][1], m_rd[0][0]});
      chk({tag, " z.busy"}, 64'(rd_busy_z), 64'({m_rb[0][1], m_rb[0][0]}));
      chk({tag, " n.data"}, rd_data_n, {m_rd[1][1], m_rd[1][0]});
      chk({tag, " n.busy"}, 64'(rd_busy_n), 64'({m_rb[1][1], m_rb[1][0]}));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_model(tag);
      $display("%s: rd_en=%b ra=%h wr_en=%b wa=%h wd=%h sb=%b/%0d fl=%b -> z=%h/%b n=%h/%b",
               tag, rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, sb_flush,
               rd_data_z, rd_busy_z, rd_data_n, rd_busy_n);
   endtask

   // ---------------- directed vectors --------------------------------------
   typedef struct packed {
      logic [1:0]  rd_en;
      logic [4:0]  ra0, ra1;
      logic [1:0]  wr_en;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        sbs;
      logic [4:0]  sba;
      logic        fl;
      logic [31:0] d0;
      logic        b0;
      logic [31:0] d1;
      logic        b1;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic sbs, input logic [4:0] sba, input logic fl,
                               input logic [31:0] d0, input logic b0,
                               input logic [31:0] d1, input logic b1);
      vec_t v;
      v.rd_en = re; v.ra0 = ra0; v.ra1 = ra1;
      v.wr_en = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
      v.sbs = sbs; v.sba = sba; v.fl = fl;
      v.d0 = d0; v.b0 = b0; v.d1 = d1; v.b1 = b1;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rd_en    = v.rd_en;
      rd_addr  = {v.ra1, v.ra0};
      wr_en    = v.wr_en;
      wr_addr  = {v.wa1, v.wa0};
      wr_data  = {v.wd1, v.wd0};
      sb_set   = v.sbs;
      sb_addr  = v.sba;
      sb_flush = v.fl;
   endtask

   vec_t tbl [21];
   vec_t idle;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //            re    ra0 ra1 we    wa0 wd0           wa1 wd1           sbs sba fl  d0            b0  d1            b1
      tbl[0]  = mk(2'b00, 0,  0,  2'b01, 3, 32'h12345678, 0,  0,            0,  0,  0,  32'h0,        0,  32'h0,        0);
      tbl[1]  = mk(2'b00, 0,  0,  2'b01, 7, 32'hCAFEF00D, 0,  0,            0,  0,  0,  32'h0,        0,  32'h0,        0);
      tbl[2]  = mk(2'b11, 3,  7,  2'b00, 0, 0,            0,  0,            0,  0,  0,  32'h12345678, 0,  32'hCAFEF00D, 0);
      tbl[3]  = mk(2'b01, 9,  0,  2'b11, 9, 32'h1,        9,  32'h2,        0,  0,  0,  32'h2,        0,  32'hCAFEF00D, 0);
      tbl[4]  = mk(2'b01, 9,  0,  2'b00, 0, 0,            0,  0,            0,  0,  0,  32'h2,        0,  32'hCAFEF00D, 0);
      tbl[5]  = mk(2'b00, 9,  0,  2'b01, 9, 32'h33,       0,  0,            0,  0,  0,  32'h2,        0,  32'hCAFEF00D, 0);
      tbl[6]  = mk(2'b00, 9,  0,  2'b10, 0, 0,            9,  32'h44,       0,  0,  0,  32'h2,        0,  32'hCAFEF00D, 0);
      tbl[7]  = mk(2'b00, 9,  0,  2'b01, 9, 32'h55,       0,  0,            0,  0,  0,  32'h2,        0,  32'hCAFEF00D, 0);
      tbl[8]  = mk(2'b01, 9,  0,  2'b00, 0, 0,            0,  0,            0,  0,  0,  32'h55,       0,  32'hCAFEF00D, 0);
      tbl[9]  = mk(2'b00, 0,  0,  2'b00, 0, 0,            0,  0,            1,  4,  0,  32'h55,       0,  32'hCAFEF00D, 0);
      tbl[10] = mk(2'b10, 0,  4,  2'b00, 0, 0,            0,  0,            0,  0,  0,  32'h55,       0,  32'h0,        1);
      tbl[11] = mk(2'b01, 4,  0,  2'b01, 4, 32'hA5,       0,  0,            0,  0,  0,  32'hA5,       0,  32'h0,        1);
      tbl[12] = mk(2'b11, 4,  4,  2'b01, 4, 32'h77,       0,  0,            1,  4,  0,  32'h77,       1,  32'h77,       1);
      tbl[13] = mk(2'b00, 0,  0,  2'b00, 0, 0,            0,  0,            1,  1,  0,  32'h77,       1,  32'h77,       1);
      tbl[14] = mk(2'b00, 0,  0,  2'b00, 0, 0,            0,  0,            1,  2,  0,  32'h77,       1,  32'h77,       1);
      tbl[15] = mk(2'b11, 1,  2,  2'b00, 0, 0,            0,  0,            1,  30, 0,  32'h0,        1,  32'h0,        1);
      tbl[16] = mk(2'b11, 30, 6,  2'b00, 0, 0,            0,  0,            1,  6,  1,  32'h0,        0,  32'h0,        0);
      tbl[17] = mk(2'b11, 1,  2,  2'b00, 0, 0,            0,  0,            0,  0,  0,  32'h0,        0,  32'h0,        0);
      tbl[18] = mk(2'b11, 3,  7,  2'b00, 0, 0,            0,  0,            0,  0,  0,  32'h12345678, 0,  32'hCAFEF00D, 0);
      tbl[19] = mk(2'b11, 4,  9,  2'b00, 0, 0,            0,  0,            0,  0,  0,  32'h77,       0,  32'h55,       0);
      tbl[20] = mk(2'b11, 10, 11, 2'b11, 10, 32'hAAAA,    11, 32'hBBBB,     0,  0,  0,  32'hAAAA,     0,  32'hBBBB,     0);
      idle    = mk(2'b00, 0,  0,  2'b00, 0, 0,            0,  0,            0,  0,  0,  0,            0,  0,            0);

      // ---- reset state ----
      drive(idle);
      rst_n = 1'b0;
      model_clear(0);
      model_clear(1);
      #1;
      chk("reset z.data", rd_data_z, 64'h0);
      chk("reset z.busy", 64'(rd_busy_z), 64'h0);
      tick("reset");
      tick("reset");
      rst_n = 1'b1;

      // ---- directed table ----
      for (int k = 0; k < 21; k++) begin
         drive(tbl[k]);
         tick($sformatf("tbl[%0d]", k));
         chk($sformatf("tbl[%0d].d0", k), 64'(rd_data_z[31:0]),  64'(tbl[k].d0));
         chk($sformatf("tbl[%0d].b0", k), 64'(rd_busy_z[0]),     64'(tbl[k].b0));
         chk($sformatf("tbl[%0d].d1", k), 64'(rd_data_z[63:32]), 64'(tbl[k].d1));
         chk($sformatf("tbl[%0d].b1", k), 64'(rd_busy_z[1]),     64'(tbl[k].b1));
      end

      // ---- zero register: ZERO_REG=1 ignores, ZERO_REG=0 behaves normally ----
      drive(mk(2'b00, 0, 0, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      tick("zero wr");
      drive(mk(2'b11, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick("zero rd");
      chk("zero z.data", rd_data_z, 64'h0);
      chk("zero z.busy", 64'(rd_busy_z), 64'h0);
      chk("zero n.data", rd_data_n, 64'hFFFFFFFF_FFFFFFFF);
      chk("zero n.busy", 64'(rd_busy_n), 64'h3);

      // ---- asynchronous reset mid-operation ----
      drive(mk(2'b00, 0, 0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 1, 5, 0, 0, 0, 0, 0));
      tick("rst wr");
      drive(mk(2'b01, 5, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick("rst rd");
      chk("pre-rst d0", 64'(rd_data_z[31:0]), 64'hDEADBEEF);
      chk("pre-rst b0", 64'(rd_busy_z[0]), 64'h1);
      #2;
      rst_n = 1'b0;
      model_clear(0);
      model_clear(1);
      #1;
      chk("async rst z.data", rd_data_z, 64'h0);
      chk("async rst n.busy", 64'(rd_busy_n), 64'h0);
      drive(mk(2'b01, 5, 0, 2'b01, 5, 32'h1234, 0, 0, 1, 5, 0, 0, 0, 0, 0));
      tick("in rst");
      tick("in rst");
      rst_n = 1'b1;
      drive(mk(2'b01, 5, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick("post rst");
      chk("post-rst d0", 64'(rd_data_z[31:0]), 64'h0);
      chk("post-rst b0", 64'(rd_busy_z[0]), 64'h0);

      // ---- randomized traffic vs model ----
      for (int n = 0; n < 500; n++) begin
         rd_en    = 2'($urandom);
         rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         wr_en    = 2'($urandom);
         wr_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         wr_data  = {$urandom, $urandom};
         sb_set   = 1'($urandom);
         sb_addr  = 5'($urandom_range(0, 7));
         sb_flush = ($urandom_range(0, 15) == 0);
         tick($sformatf("rnd[%0d]", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file. Next generation of the core's 2-read/1-write register block.
- Configurable width and depth, with N read ports and M write ports.
- Registered (1-cycle) reads with write-first bypass, an optional hardwired zero register, and a per-register pending-write scoreboard for pipeline hazard detection.
- Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers; power of two, >= 2
- ADDR_W, $clog2(DEPTH), address width (derived)
- NUM_RD, 2, read ports, 1..4
- NUM_WR, 1, write ports, 1..2
- ZERO_REG, 1, if 1 then register 0 always reads 0, ignores writes, and is never busy

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data, packed as rd_addr
- rd_busy  out  NUM_RD  registered pending flag of the addressed register
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- sb_set  in  1  mark register sb_addr as pending (instruction issued)
- sb_addr  in  ADDR_W  scoreboard set address
- sb_flush  in  1  clear all pending flags (pipeline flush)

Behaviour:
- Reset (rst_n=0, async): all registers = 0, all busy bits = 0, rd_data = 0, rd_busy = 0. Held while rst_n low; first update on the first rising edge after release.
- Write: on each edge, for each port j with wr_en[j]=1, mem[wr_addr[j]] <= wr_data[j].
  - Same-address multi-port write: highest port index wins.
  - Write to address 0 with ZERO_REG=1: discarded.
- Read: latency 1. On an edge with rd_en[i]=1, rd_data[i] <= next-state value of mem[rd_addr[i]].
  - Write-first: a same-cycle write to that address is forwarded, using the same port-priority rule.
  - rd_en[i]=0: rd_data[i] and rd_busy[i] hold.
  - Address 0 with ZERO_REG=1: rd_data[i] <= 0.
- Scoreboard, per-register busy bit, evaluated in this priority order:
  1. sb_flush=1: all busy <= 0; sb_set ignored.
  2. Otherwise sb_set=1: busy[sb_addr] <= 1. Set wins over a same-cycle write-clear to the same address (new producer issued).
  3. Otherwise any wr_en[j]=1 to address a: busy[a] <= 0.
  - ZERO_REG=1: busy[0] is constant 0.
- rd_busy[i] is updated with rd_data[i] and reflects the next-state busy bit, so both outputs describe the same post-edge view.
- Out-of-range addresses cannot occur because DEPTH is a power of two.
- No combinational path from inputs to outputs.
- Reset mid-operation: everything clears immediately, including pending flags. In-flight writes on that edge are lost.

Test Plan:
- Reset → all outputs zero: drive rst_n=0 mid-run after writing 0xDEADBEEF to r5. Then read r5 → rd_data=0 and rd_busy=0 one cycle after the read.
- Basic write/read: write r3=0x12345678, r7=0xCAFEF00D on successive cycles. Read r3 on port 0 and r7 on port 1 in the same cycle → next cycle port0=0x12345678, port1=0xCAFEF00D.
- Bypass and priority (NUM_WR=2):
  - Same cycle: port0 writes r9=0x1, port1 writes r9=0x2, and rd_addr0=9 → next cycle rd_data0=0x2, and a later read also gives 0x2.
  - Read-enable low for 3 cycles while r9 changes → rd_data0 holds.
- Zero register: write r0=0xFFFFFFFF and sb_set with sb_addr=0 → reads of r0 give 0 and rd_busy=0. Repeat with ZERO_REG=0 → reads give 0xFFFFFFFF and busy=1.
- Scoreboard lifecycle:
  - sb_set r4 → rd_busy=1 for r4 on the next read.
  - Write r4=0xA5 → busy clears, and a same-cycle read returns data 0xA5 with busy=0.
  - Simultaneous sb_set r4 and write r4 → busy=1.
- Flush: set busy on r1, r2, r30, then assert sb_flush together with sb_set r6 → all four (r1, r2, r30, r6) read busy=0. Register contents unchanged.
